playlist_controller: RTL
========================

Name: playlist_controller

Overview:
Top-level sequencer for the song playback path. It turns user button pulses (play/pause, next, previous) and song-reader completion into the `play`, `song` and reader-flush controls that drive the song reader.
- It flushes the reader between songs so each song restarts at note 0.
- It auto-advances through the playlist and either loops or stops at the end.

Parameters:
- SONG_W, 2, width of the song index; must match the song reader's song select.
- NUM_SONGS, 4, number of songs in the playlist, 1..2**SONG_W.
- LOOP_ALL, 1, 1 = after the last song wrap to song 0 and keep playing; 0 = wrap to song 0 and pause.
- FLUSH_CYCLES, 2, cycles `reset_player` is held high on every song change, 1..15.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset; asserted when reset==0.
- play_btn  input  1  one-cycle pulse (already debounced/edge-detected); toggles play/pause.
- next_btn  input  1  one-cycle pulse; skip to next song.
- prev_btn  input  1  one-cycle pulse; go to previous song.
- song_done  input  1  from song reader; high when the final note of the current song completes.
- play  output  1  to song reader; high = advance through notes.
- song  output  SONG_W  to song reader; current song index.
- reset_player  output  1  to song reader reset (active-high); flushes the note address and state.
- song_changed  output  1  one-cycle pulse on the first cycle of each flush, for the display.

Behaviour:
- Registers:
  - state: PAUSED, PLAYING, FLUSH.
  - song_q [SONG_W].
  - resume_q: play status to restore after a flush.
  - flush_cnt [4].
- Reset (reset==0 at a clock edge):
  - state=FLUSH, song_q=0, resume_q=0, flush_cnt=0.
  - Outputs while held in reset: play=0, song=0, reset_player=1, song_changed=0.
- Output decode, all registered-state based with no combinational input-to-output path:
  - play = (state==PLAYING).
  - reset_player = (state==FLUSH).
  - song = song_q.
  - song_changed = (state==FLUSH && flush_cnt==0 && !first_after_reset). Set first_after_reset on reset; clear it on leaving FLUSH.
- PAUSED:
  - play_btn -> PLAYING.
  - next_btn -> song_q = inc(song_q), resume_q=0, flush_cnt=0, go FLUSH.
  - prev_btn -> song_q = dec(song_q), resume_q=0, go FLUSH.
  - song_done is ignored.
- PLAYING:
  - play_btn -> PAUSED.
  - next_btn or song_done -> song_q = inc(song_q), go FLUSH. resume_q=1, except when song_done occurs on song NUM_SONGS-1 with LOOP_ALL==0; then resume_q=0.
  - prev_btn -> song_q = dec(song_q), resume_q=1, go FLUSH.
- FLUSH:
  - flush_cnt increments each cycle.
  - When flush_cnt==FLUSH_CYCLES-1, go to PLAYING if resume_q else PAUSED, and clear flush_cnt.
  - All buttons and song_done are ignored (dropped, not queued) during FLUSH.
- Index arithmetic, modulo NUM_SONGS (not 2**SONG_W):
  - inc(NUM_SONGS-1)=0, otherwise +1.
  - dec(0)=NUM_SONGS-1, otherwise -1.
- Priority for simultaneous inputs in one cycle: next_btn && prev_btn together = both ignored; then play_btn > next/song_done > prev.
  - play_btn together with next_btn in PLAYING = pause only; the next press is dropped.
  - song_done together with next_btn = one advance only, never two.
- Latency:
  - Button to play change: 1 cycle.
  - Song change to song_q update: 1 cycle.
  - Song change to play resume: FLUSH_CYCLES+1 cycles after the triggering edge.
- song_done may stay high for more than one cycle. The FLUSH interval resets the reader, so a stale song_done is never seen in PLAYING.
- NUM_SONGS==1: inc and dec always give 0; next and prev still flush (restart the song).

Decomposition:
- Shared package (music_pkg) holds:
  - the state encodings (PAUSED/PLAYING/FLUSH as 2-bit constants);
  - the default SONG_W;
  - the reset polarity constant.
- One sub-module, playlist_index: modulo-NUM_SONGS up/down counter with enable, direction and sync clear. It is reused later for volume or tempo steps.
- State and counter registers use the team dffr/dffre primitives, with reset inverted once at the top of this block.

Test Plan:
- Reset held 3 cycles then released -> play=0, song=0, reset_player=1 for exactly 2 cycles, then PAUSED; song_changed stays 0 throughout.
- From PAUSED, play_btn pulse at cycle t -> play=1 at t+1; second pulse at t+5 -> play=0 at t+6; song stays 0.
- PLAYING song 3, song_done pulse -> song=0 next cycle, reset_player high 2 cycles, song_changed one pulse, play=1 again at t+3. Repeat with LOOP_ALL=0 -> play stays 0 after the flush.
- PAUSED song 0, prev_btn -> song=3, reset_player 2 cycles, play remains 0. Repeat with NUM_SONGS=3 -> song=2.
- PLAYING song 1: next_btn and song_done in the same cycle -> song=2, not 3. next_btn and prev_btn together -> no change, no flush.
- During FLUSH, pulse next_btn, play_btn and song_done -> all ignored; final song and play match the values fixed at flush entry. Apply reset==0 mid-flush -> song=0, play=0, flush restarts.

Source files
------------

// File: rtl/music_pkg.sv
// Shared encodings and defaults for the song playback path.
package music_pkg;

    typedef enum logic [1:0] {
        StPaused  = 2'd0,
        StPlaying = 2'd1,
        StFlush   = 2'd2
    } state_e;

    localparam int unsigned SongWDefault = 2;

    // Level of the top-level reset pin that means "in reset".
    localparam logic RstActive = 1'b0;

endpackage

// File: rtl/dffr.sv
// Flop with synchronous active-high reset to a parameterised value.
module dffr #(
    parameter int unsigned       Width  = 1,
    parameter logic [Width-1:0]  RstVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o <= RstVal;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/dffre.sv
// Flop with synchronous active-high reset and load enable.
module dffre #(
    parameter int unsigned       Width  = 1,
    parameter logic [Width-1:0]  RstVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o <= RstVal;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/playlist_index.sv
// Modulo-NumVals up/down counter with enable and synchronous clear.
module playlist_index #(
    parameter int unsigned Width   = 2,
    parameter int unsigned NumVals = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             up_i,
    output logic [Width-1:0] idx_o
);

    localparam logic [Width-1:0] MaxIdx = Width'(NumVals - 1);

    logic [Width-1:0] idx_d;
    logic             load;

    // Wrap at NumVals rather than 2**Width so short lists never reach unused indices.
    always_comb begin
        idx_d = '0;
        if (!clr_i) begin
            if (up_i) begin
                idx_d = (idx_o == MaxIdx) ? '0 : idx_o + Width'(1);
            end else begin
                idx_d = (idx_o == '0) ? MaxIdx : idx_o - Width'(1);
            end
        end
    end

    assign load = en_i | clr_i;

    dffre #(
        .Width (Width),
        .RstVal('0)
    ) u_idx_reg (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .en_i (load),
        .d_i  (idx_d),
        .q_o  (idx_o)
    );

endmodule

// File: rtl/playlist_controller.sv
// Playback sequencer: turns button pulses and song completion into play/song/flush
// controls for the song reader, flushing the reader on every song change.
module playlist_controller
    import music_pkg::*;
#(
    parameter int unsigned SONG_W       = SongWDefault,
    parameter int unsigned NUM_SONGS    = 4,
    parameter int unsigned LOOP_ALL     = 1,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_btn,
    input  logic              next_btn,
    input  logic              prev_btn,
    input  logic              song_done,
    output logic              play,
    output logic [SONG_W-1:0] song,
    output logic              reset_player,
    output logic              song_changed
);

    localparam logic [SONG_W-1:0] LastSong  = SONG_W'(NUM_SONGS - 1);
    localparam logic [3:0]        FlushLast = 4'(FLUSH_CYCLES - 1);
    localparam logic              StopAtEnd = (LOOP_ALL == 0);

    logic rst;
    assign rst = (reset == RstActive);

    state_e      state_q, state_d;
    logic [1:0]  state_raw;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic        resume_q, resume_d;
    logic        first_q, first_d;
    logic [SONG_W-1:0] song_q;
    logic        idx_en, idx_up;
    logic        nav_next, nav_prev;

    // Opposing skips in the same cycle cancel each other.
    assign nav_next = next_btn & ~prev_btn;
    assign nav_prev = prev_btn & ~next_btn;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        resume_d    = resume_q;
        first_d     = first_q;
        idx_en      = 1'b0;
        idx_up      = 1'b1;
        unique case (state_q)
            StPaused: begin
                if (play_btn) begin
                    state_d = StPlaying;
                end else if (nav_next || nav_prev) begin
                    idx_en      = 1'b1;
                    idx_up      = nav_next;
                    resume_d    = 1'b0;
                    flush_cnt_d = '0;
                    state_d     = StFlush;
                end
            end
            StPlaying: begin
                if (play_btn) begin
                    state_d = StPaused;
                end else if (nav_next || song_done) begin
                    idx_en      = 1'b1;
                    resume_d    = ~(song_done && StopAtEnd && (song_q == LastSong));
                    flush_cnt_d = '0;
                    state_d     = StFlush;
                end else if (nav_prev) begin
                    idx_en      = 1'b1;
                    idx_up      = 1'b0;
                    resume_d    = 1'b1;
                    flush_cnt_d = '0;
                    state_d     = StFlush;
                end
            end
            StFlush: begin
                if (flush_cnt_q == FlushLast) begin
                    state_d     = resume_q ? StPlaying : StPaused;
                    flush_cnt_d = '0;
                    first_d     = 1'b0;
                end else begin
                    flush_cnt_d = flush_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d     = StFlush;
                flush_cnt_d = '0;
            end
        endcase
    end

    dffr #(.Width(2), .RstVal(2'(StFlush))) u_state_reg (
        .clk_i(clk),
        .rst_i(rst),
        .d_i  (state_d),
        .q_o  (state_raw)
    );
    assign state_q = state_e'(state_raw);

    dffr #(.Width(4), .RstVal(4'd0)) u_flush_cnt_reg (
        .clk_i(clk),
        .rst_i(rst),
        .d_i  (flush_cnt_d),
        .q_o  (flush_cnt_q)
    );

    dffr #(.Width(1), .RstVal(1'b0)) u_resume_reg (
        .clk_i(clk),
        .rst_i(rst),
        .d_i  (resume_d),
        .q_o  (resume_q)
    );

    // Suppresses the display pulse for the power-on flush.
    dffr #(.Width(1), .RstVal(1'b1)) u_first_reg (
        .clk_i(clk),
        .rst_i(rst),
        .d_i  (first_d),
        .q_o  (first_q)
    );

    playlist_index #(
        .Width  (SONG_W),
        .NumVals(NUM_SONGS)
    ) u_song_index (
        .clk_i(clk),
        .rst_i(rst),
        .clr_i(1'b0),
        .en_i (idx_en),
        .up_i (idx_up),
        .idx_o(song_q)
    );

    assign play         = (state_q == StPlaying);
    assign reset_player = (state_q == StFlush);
    assign song         = song_q;
    assign song_changed = (state_q == StFlush) && (flush_cnt_q == 4'd0) && !first_q;

endmodule
